// File: rtl/sub_pkg.sv
// sub_pkg: shared FSM state encoding and width limits for the serial subtractor
package sub_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int MIN_WIDTH = 2;
endpackage

// File: rtl/serial_subtractor_ctrl_cell.sv
// serial_subtractor_ctrl_cell: one-bit full subtractor built from two half subtractors
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);
  assign d = x ^ y;
  assign b = ~x & y;
endmodule

module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic w_d1, w_b1, w_b2;
  half_subtractor u_hs0 (.x(x), .y(y), .d(w_d1), .b(w_b1));
  half_subtractor u_hs1 (.x(w_d1), .y(bin), .d(d), .b(w_b2));
  assign bout = w_b1 | w_b2;
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial unsigned a-b, LSB first, one bit per clock
module serial_subtractor_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bor,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_diff, w_res;
  logic [CW-1:0]    r_cnt;
  logic             r_bin, r_bor, r_zero, w_d, w_bout, w_last, w_load;
  full_subtractor_cell u_cell (.x(r_a[0]), .y(r_b[0]), .bin(r_bin), .d(w_d), .bout(w_bout));
  assign w_res  = {w_d, r_res[WIDTH-1:1]};
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign w_load = start && r_state != SHIFT;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == SHIFT) ? (w_last ? DONE : SHIFT) : (start ? SHIFT : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // Result registers update only on the final bit so they hold during SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_bin  <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bor  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_load) begin
      r_a   <= a;
      r_b   <= b;
      r_bin <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= w_res;
      r_bin <= w_bout;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= w_res;
        r_bor  <= w_bout;
        r_zero <= w_res == '0;
      end
    end
  end
  assign busy = r_state == SHIFT;
  assign done = r_state == DONE;
  assign diff = r_diff;
  assign bor  = r_bor;
  assign zero = r_zero;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: scoreboard bench with an arithmetic reference model
module tb_serial_subtractor_ctrl;
  typedef struct {
    logic [7:0] d;
    logic       b;
    logic       z;
    int         due;
  } exp_t;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] a = '0, b = '0, diff;
  logic       busy, done, bor, zero;
  int         cyc = 0, checks = 0, errors = 0;
  exp_t       q[$];
  logic [7:0] last_d = '0;
  logic       last_b = 1'b0, last_z = 1'b0;

  serial_subtractor_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bor(bor), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares whenever DUT should or does present a result
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() != 0 && cyc == q[0].due) begin
        chk("done_pulse", done, 1);
        chk("diff", diff, q[0].d);
        chk("bor", bor, q[0].b);
        chk("zero", zero, q[0].z);
        last_d = q[0].d;
        last_b = q[0].b;
        last_z = q[0].z;
        void'(q.pop_front());
      end else begin
        chk("no_done", done, 0);
        chk("diff_hold", diff, last_d);
        chk("bor_hold", bor, last_b);
        chk("zero_hold", zero, last_z);
      end
      chk("busy", busy, q.size() != 0 && cyc >= q[0].due - 8 && cyc < q[0].due);
      chk("busy_done_excl", busy & done, 0);
    end
  end

  task automatic issue(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] d;
    d = x - y;
    a = x;
    b = y;
    start = 1'b1;
    q.push_back('{d, x < y, d == 0, cyc + 9});
  endtask

  task automatic op(input logic [7:0] x, input logic [7:0] y);
    issue(x, y);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_diff"}, diff, 0);
    chk({tag, "_bor"}, bor, 0);
    chk({tag, "_zero"}, zero, 0);
  endtask

  initial begin
    logic [7:0] x, y;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    op(8'h05, 8'h03); drain();
    op(8'h03, 8'h05); drain();
    op(8'h00, 8'h01); drain();
    op(8'hA7, 8'hA7); drain();
    op(8'h00, 8'h00); drain();
    // A start mid-operation must be ignored
    op(8'h10, 8'h01);
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    // Back-to-back: second start held during the DONE cycle
    op(8'h3C, 8'h4D);
    repeat (8) @(negedge clk);
    op(8'h9E, 8'h12);
    drain();
    // Reset in the middle of SHIFT aborts without a done pulse
    op(8'h55, 8'h22);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    last_d = '0; last_b = 1'b0; last_z = 1'b0;
    #1 check_zero_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    op(8'h80, 8'h01); drain();
    for (int n = 0; n < 40; n++) begin
      x = 8'($urandom);
      y = ($urandom_range(0, 4) == 0) ? x : 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          op(x, y);
          repeat (8) @(negedge clk);
          op(y, x);
        end
        1: begin
          op(x, y);
          for (int k = 0; k < 7; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            start = 1'($urandom);
            @(negedge clk);
          end
          start = 1'b0;
        end
        default: op(x, y);
      endcase
      drain();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
